// File: rtl/i2c_bus_monitor.sv
// Multi-channel I2C bus monitor: synchronise and glitch-filter SCL/SDA, detect START/Sr/STOP,
// track the 9-bit frame position and count framing violations. Optional I2C_MON_BYTE_CAPTURE_EN adds byte capture.
module i2c_bus_monitor #(
    parameter int NUM_CH     = 1,
    parameter int FILT_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  logic                    system_clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       scl_i,
    input  logic [NUM_CH-1:0]       sda_i,
    input  logic [NUM_CH-1:0]       clr_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       start_o,
    output logic [NUM_CH-1:0]       rstart_o,
    output logic [NUM_CH-1:0]       stop_o,
    output logic [NUM_CH-1:0]       err_o,
    output logic [2*NUM_CH-1:0]     err_code_o,
    output logic [4*NUM_CH-1:0]     bit_cnt_o,
`ifdef I2C_MON_BYTE_CAPTURE_EN
    output logic [NUM_CH-1:0]       byte_vld_o,
    output logic [8*NUM_CH-1:0]     byte_o,
    output logic [NUM_CH-1:0]       ack_o,
`endif
    output logic [CNT_W*NUM_CH-1:0] err_cnt_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam int FCW = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;
    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Line index 0 is SCL, 1 is SDA.
        logic [1:0] line_raw, line_filt, line_prev;
        logic       scl_rise, scl_high, start_evt, stop_evt;

        assign line_raw = {sda_i[gi], scl_i[gi]};

        for (genvar li = 0; li < 2; li++) begin : g_line
            logic [1:0]     sync_reg;
            logic           filt_reg, prev_reg;
            logic [FCW-1:0] run_reg;

            // run_reg counts consecutive synchronised samples that disagree with the filtered level.
            always_ff @(posedge system_clock) begin
                if (reset) begin
                    sync_reg <= 2'b11;
                    filt_reg <= 1'b1;
                    prev_reg <= 1'b1;
                    run_reg  <= '0;
                end else begin
                    sync_reg <= {sync_reg[0], line_raw[li]};
                    prev_reg <= filt_reg;
                    if (sync_reg[1] == filt_reg) begin
                        run_reg <= '0;
                    end else if (run_reg == FILT_LAST) begin
                        filt_reg <= sync_reg[1];
                        run_reg  <= '0;
                    end else begin
                        run_reg <= run_reg + 1'b1;
                    end
                end
            end

            assign line_filt[li] = filt_reg;
            assign line_prev[li] = prev_reg;
        end

        // Bus conditions need SCL stably high across the SDA edge; anything else is a data change.
        assign scl_rise  = line_filt[0] & ~line_prev[0];
        assign scl_high  = line_filt[0] & line_prev[0];
        assign start_evt = scl_high & line_prev[1] & ~line_filt[1];
        assign stop_evt  = scl_high & ~line_prev[1] & line_filt[1];

        state_t           state_reg, state_next;
        logic [3:0]       bit_cnt_reg, bit_cnt_next;
        logic [1:0]       err_code_reg, err_code_next;
        logic             start_reg, start_next, rstart_reg, rstart_next;
        logic             stop_reg, stop_next, err_reg, err_next;
        logic [CNT_W-1:0] err_cnt_reg;

        always_ff @(posedge system_clock) begin
            if (reset) begin
                state_reg    <= ST_IDLE;
                bit_cnt_reg  <= 4'd0;
                err_code_reg <= 2'b00;
                start_reg    <= 1'b0;
                rstart_reg   <= 1'b0;
                stop_reg     <= 1'b0;
                err_reg      <= 1'b0;
            end else begin
                state_reg    <= state_next;
                bit_cnt_reg  <= bit_cnt_next;
                err_code_reg <= err_code_next;
                start_reg    <= start_next;
                rstart_reg   <= rstart_next;
                stop_reg     <= stop_next;
                err_reg      <= err_next;
            end
        end

        always_comb begin
            state_next    = state_reg;
            bit_cnt_next  = bit_cnt_reg;
            err_code_next = err_code_reg;
            start_next    = 1'b0;
            rstart_next   = 1'b0;
            stop_next     = 1'b0;
            err_next      = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_evt) begin
                        start_next   = 1'b1;
                        bit_cnt_next = 4'd0;
                        state_next   = ST_BUSY;
                    end else if (scl_rise) begin
                        err_next      = 1'b1;
                        err_code_next = 2'b11;
                    end
                end
                ST_BUSY: begin
                    // A condition is legal only right after the SCL rise that follows a complete 9-bit frame.
                    if (scl_rise) begin
                        bit_cnt_next = (bit_cnt_reg == 4'd8) ? 4'd0 : bit_cnt_reg + 4'd1;
                    end else if (start_evt) begin
                        rstart_next  = 1'b1;
                        bit_cnt_next = 4'd0;
                        if (bit_cnt_reg != 4'd1) begin
                            err_next      = 1'b1;
                            err_code_next = 2'b01;
                        end
                    end else if (stop_evt) begin
                        stop_next    = 1'b1;
                        bit_cnt_next = 4'd0;
                        state_next   = ST_IDLE;
                        if (bit_cnt_reg != 4'd1) begin
                            err_next      = 1'b1;
                            err_code_next = 2'b10;
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge system_clock) begin
            if (reset || clr_i[gi]) begin
                err_cnt_reg <= '0;
            end else if (err_next && err_cnt_reg != CNT_MAX) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end

        assign busy_o[gi]                   = (state_reg == ST_BUSY);
        assign start_o[gi]                  = start_reg;
        assign rstart_o[gi]                 = rstart_reg;
        assign stop_o[gi]                   = stop_reg;
        assign err_o[gi]                    = err_reg;
        assign err_code_o[2*gi +: 2]        = err_code_reg;
        assign bit_cnt_o[4*gi +: 4]         = bit_cnt_reg;
        assign err_cnt_o[CNT_W*gi +: CNT_W] = err_cnt_reg;

`ifdef I2C_MON_BYTE_CAPTURE_EN
        logic [7:0] shift_reg, byte_reg;
        logic       ack_reg, byte_vld_reg;

        always_ff @(posedge system_clock) begin
            if (reset) begin
                shift_reg    <= 8'h00;
                byte_reg     <= 8'h00;
                ack_reg      <= 1'b0;
                byte_vld_reg <= 1'b0;
            end else begin
                byte_vld_reg <= 1'b0;
                if (start_evt) begin
                    shift_reg <= 8'h00;
                end else if (scl_rise && state_reg == ST_BUSY) begin
                    if (bit_cnt_reg <= 4'd7) begin
                        shift_reg <= {shift_reg[6:0], line_filt[1]};
                    end else begin
                        byte_reg     <= shift_reg;
                        ack_reg      <= line_filt[1];
                        byte_vld_reg <= 1'b1;
                    end
                end
            end
        end

        assign byte_vld_o[gi]     = byte_vld_reg;
        assign byte_o[8*gi +: 8]  = byte_reg;
        assign ack_o[gi]          = ack_reg;
`endif
    end

endmodule
